mem_access_stage: RTL and testbench

Memory-stage controller on the consuming side of the EX/MEM pipeline register. It reads the registered MEM-stage fields, drives a req/ack data-memory port, stalls the pipeline while the access is outstanding, resolves branch/jump redirection and registers the MEM/WB fields for write-back. It sits between the EX/MEM register outputs and the register-file write-back path.

---
 rtl/mem_access_stage_pkg.sv | 20 ++
 rtl/mem_access_stage_mem_wb_reg.sv | 50 +++++
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 tb/tb_mem_access_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: widths, the
// default access timeout and the req/ack controller state encoding.
package mem_access_stage_pkg;

  localparam int DATA_W           = 32;
  localparam int REG_W            = 5;
  localparam int MAX_WAIT_DEFAULT = 15;
  localparam int WAIT_CNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // A word access must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register. A stalled edge inserts a bubble by clearing
// the write-back controls while the data fields keep their last values.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = mem_access_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] ReadData_WB,
  output logic [DATA_W-1:0] resultadoALU_WB,
  output logic              MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  WriteReg_WB
);

  // Data fields advance only on non-stalled edges and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData_WB     <= '0;
      resultadoALU_WB <= '0;
      WriteReg_WB     <= '0;
    end else if (!stall) begin
      ReadData_WB     <= read_data;
      resultadoALU_WB <= alu_result;
      WriteReg_WB     <= write_reg;
    end
  end

  // Control fields follow the instruction, or drop to a bubble when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemToReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
    end else if (stall) begin
      MemToReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
    end else begin
      MemToReg_WB <= mem_to_reg;
      RegWrite_WB <= reg_write;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage controller: drives the req/ack data-memory port from the
// EX/MEM fields, stalls while an access is outstanding, aborts accesses
// that wait too long, resolves branch/jump redirection and feeds MEM/WB.
module mem_access_stage #(
  parameter int DATA_W   = mem_access_stage_pkg::DATA_W,
  parameter int MAX_WAIT = mem_access_stage_pkg::MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] PC_next_MEM,
  input  logic              zeroALU_MEM,
  input  logic [DATA_W-1:0] resultadoALU_MEM,
  input  logic [DATA_W-1:0] Read_Data_2_MEM,
  input  logic              Branch_MEM,
  input  logic              Jump_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              MemToReg_MEM,
  input  logic              RegWrite_MEM,
  input  logic [4:0]        WriteReg_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_MEM,
  output logic              PCSrc_MEM,
  output logic [DATA_W-1:0] ReadData_WB,
  output logic [DATA_W-1:0] resultadoALU_WB,
  output logic              MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [4:0]        WriteReg_WB,
  output logic              misalign_err,
  output logic              bus_err
);

  import mem_access_stage_pkg::*;

  // The abort fires in the last permitted WAIT cycle; the counter reads 0
  // in the first WAIT cycle, so that is MAX_WAIT-1.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  mem_state_t            state;
  mem_state_t            state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_next;

  logic              access;
  logic              misaligned;
  logic              req_raw;
  logic              stall_raw;
  logic              abort;
  logic              read_ok;
  logic              take_branch;
  logic [DATA_W-1:0] wb_read_data;
  logic              wb_reg_write;
  logic              unused_pc;

  // The redirect target is consumed by the fetch stage, not here.
  assign unused_pc = ^PC_next_MEM;

  assign access     = MemRead_MEM | MemWrite_MEM;
  assign misaligned = access & ~is_word_aligned(resultadoALU_MEM[1:0]);

  // State and wait counter; reset drops any outstanding access back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Request/stall/abort decisions and next state for the req/ack handshake.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    req_raw       = 1'b0;
    stall_raw     = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        req_raw = access & ~misaligned;
        if (req_raw && !dmem_ack) begin
          stall_raw     = 1'b1;
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_raw    = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          req_raw       = 1'b1;
          stall_raw     = 1'b1;
          wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Every port-facing combinational output is forced low while in reset.
  always_comb begin
    dmem_req   = req_raw & rst_n;
    stall_MEM  = stall_raw & rst_n;
    dmem_we    = MemWrite_MEM & rst_n;
    dmem_addr  = resultadoALU_MEM & {DATA_W{rst_n}};
    dmem_wdata = Read_Data_2_MEM & {DATA_W{rst_n}};
    PCSrc_MEM  = take_branch & ~stall_raw & rst_n;
  end

  assign take_branch = (Branch_MEM & zeroALU_MEM) | Jump_MEM;

  // A read delivers data only when acked and not also a write.
  assign read_ok      = MemRead_MEM & ~MemWrite_MEM & req_raw & dmem_ack;
  assign wb_read_data = read_ok ? dmem_rdata : '0;
  assign wb_reg_write = RegWrite_MEM & ~abort & ~misaligned;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (misaligned) misalign_err <= 1'b1;
      if (abort)      bus_err      <= 1'b1;
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall_MEM),
    .read_data      (wb_read_data),
    .alu_result     (resultadoALU_MEM),
    .mem_to_reg     (MemToReg_MEM),
    .reg_write      (wb_reg_write),
    .write_reg      (WriteReg_MEM),
    .ReadData_WB    (ReadData_WB),
    .resultadoALU_WB(resultadoALU_WB),
    .MemToReg_WB    (MemToReg_WB),
    .RegWrite_WB    (RegWrite_WB),
    .WriteReg_WB    (WriteReg_WB)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instruction sequences with literal
// expectations, plus a cycle-by-cycle comparison against a behavioural model.
module tb_mem_access_stage;

  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] PC_next_MEM = '0;
  logic              zeroALU_MEM = 1'b0;
  logic [DATA_W-1:0] resultadoALU_MEM = '0;
  logic [DATA_W-1:0] Read_Data_2_MEM = '0;
  logic              Branch_MEM = 1'b0;
  logic              Jump_MEM = 1'b0;
  logic              MemRead_MEM = 1'b0;
  logic              MemWrite_MEM = 1'b0;
  logic              MemToReg_MEM = 1'b0;
  logic              RegWrite_MEM = 1'b0;
  logic [4:0]        WriteReg_MEM = '0;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic              dmem_ack = 1'b0;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              stall_MEM;
  logic              PCSrc_MEM;
  logic [DATA_W-1:0] ReadData_WB;
  logic [DATA_W-1:0] resultadoALU_WB;
  logic              MemToReg_WB;
  logic              RegWrite_WB;
  logic [4:0]        WriteReg_WB;
  logic              misalign_err;
  logic              bus_err;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC_next_MEM     (PC_next_MEM),
    .zeroALU_MEM     (zeroALU_MEM),
    .resultadoALU_MEM(resultadoALU_MEM),
    .Read_Data_2_MEM (Read_Data_2_MEM),
    .Branch_MEM      (Branch_MEM),
    .Jump_MEM        (Jump_MEM),
    .MemRead_MEM     (MemRead_MEM),
    .MemWrite_MEM    (MemWrite_MEM),
    .MemToReg_MEM    (MemToReg_MEM),
    .RegWrite_MEM    (RegWrite_MEM),
    .WriteReg_MEM    (WriteReg_MEM),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .stall_MEM       (stall_MEM),
    .PCSrc_MEM       (PCSrc_MEM),
    .ReadData_WB     (ReadData_WB),
    .resultadoALU_WB (resultadoALU_WB),
    .MemToReg_WB     (MemToReg_WB),
    .RegWrite_WB     (RegWrite_WB),
    .WriteReg_WB     (WriteReg_WB),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Behavioural model: "age" is how many cycles the current access has
  // already spent stalled; once it has stalled MAX_WAIT times without an
  // ack it is abandoned.
  int                age = 0;
  logic              exp_access, exp_misaligned, exp_abort, exp_stall;
  logic              exp_req, exp_we, exp_pcsrc, exp_read_ok;
  logic [DATA_W-1:0] exp_addr, exp_wdata;
  logic [DATA_W-1:0] m_read_data, m_alu;
  logic              m_mem_to_reg, m_reg_write, m_misalign, m_bus;
  logic [4:0]        m_write_reg;

  // Combinational expectations derived from the current inputs and age.
  always_comb begin
    exp_access     = MemRead_MEM || MemWrite_MEM;
    exp_misaligned = exp_access && (resultadoALU_MEM % 4 != 0);
    exp_abort      = rst_n && exp_access && !exp_misaligned && !dmem_ack && (age == MAX_WAIT);
    exp_stall      = rst_n && exp_access && !exp_misaligned && !dmem_ack && (age < MAX_WAIT);
    exp_req        = rst_n && exp_access && !exp_misaligned && !exp_abort;
    exp_we         = rst_n && MemWrite_MEM;
    exp_addr       = rst_n ? resultadoALU_MEM : '0;
    exp_wdata      = rst_n ? Read_Data_2_MEM : '0;
    exp_pcsrc      = rst_n && ((Branch_MEM && zeroALU_MEM) || Jump_MEM) && !exp_stall;
    exp_read_ok    = exp_req && dmem_ack && MemRead_MEM && !MemWrite_MEM;
  end

  // Model of the registered write-back fields and sticky flags.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age          <= 0;
      m_read_data  <= '0;
      m_alu        <= '0;
      m_mem_to_reg <= 1'b0;
      m_reg_write  <= 1'b0;
      m_write_reg  <= '0;
      m_misalign   <= 1'b0;
      m_bus        <= 1'b0;
    end else if (exp_stall) begin
      age          <= age + 1;
      m_mem_to_reg <= 1'b0;
      m_reg_write  <= 1'b0;
    end else begin
      age          <= 0;
      m_read_data  <= exp_read_ok ? dmem_rdata : '0;
      m_alu        <= resultadoALU_MEM;
      m_mem_to_reg <= MemToReg_MEM;
      m_reg_write  <= RegWrite_MEM && !exp_abort && !exp_misaligned;
      m_write_reg  <= WriteReg_MEM;
      if (exp_misaligned) m_misalign <= 1'b1;
      if (exp_abort)      m_bus      <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge compares all DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("cmp_req", dmem_req, exp_req);
    checkOutput("cmp_we", dmem_we, exp_we);
    checkOutput("cmp_addr", dmem_addr, exp_addr);
    checkOutput("cmp_wdata", dmem_wdata, exp_wdata);
    checkOutput("cmp_stall", stall_MEM, exp_stall);
    checkOutput("cmp_pcsrc", PCSrc_MEM, exp_pcsrc);
    checkOutput("cmp_rdata_wb", ReadData_WB, m_read_data);
    checkOutput("cmp_alu_wb", resultadoALU_WB, m_alu);
    checkOutput("cmp_m2r_wb", MemToReg_WB, m_mem_to_reg);
    checkOutput("cmp_rw_wb", RegWrite_WB, m_reg_write);
    checkOutput("cmp_wreg_wb", WriteReg_WB, m_write_reg);
    checkOutput("cmp_misalign", misalign_err, m_misalign);
    checkOutput("cmp_bus", bus_err, m_bus);
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic m2r,
                               input logic rw, input logic br, input logic jmp,
                               input logic zero, input logic [DATA_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               input logic [DATA_W-1:0] pc, input logic [4:0] wreg);
    MemRead_MEM      = rd;
    MemWrite_MEM     = wr;
    MemToReg_MEM     = m2r;
    RegWrite_MEM     = rw;
    Branch_MEM       = br;
    Jump_MEM         = jmp;
    zeroALU_MEM      = zero;
    resultadoALU_MEM = addr;
    Read_Data_2_MEM  = wdata;
    PC_next_MEM      = pc;
    WriteReg_MEM     = wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int stall_cycles;

  // Directed scenarios with hand-computed expectations.
  initial begin
    $display("[TB] start");

    // Reset held low: every output reads 0 even with a request pending.
    applyStimulus(1, 0, 1, 1, 1, 1, 1, 32'h100, 32'h5, 32'h40, 5'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_req", dmem_req, 0);
      checkOutput("rst_stall", stall_MEM, 0);
      checkOutput("rst_pcsrc", PCSrc_MEM, 0);
      checkOutput("rst_addr", dmem_addr, 0);
      checkOutput("rst_rw_wb", RegWrite_WB, 0);
    end
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // ALU pass-through.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'hA5, 0, 0, 5'd7);
    @(negedge clk);
    checkOutput("alu_stall", stall_MEM, 0);
    step();
    checkOutput("alu_res_wb", resultadoALU_WB, 32'hA5);
    checkOutput("alu_rw_wb", RegWrite_WB, 1);
    checkOutput("alu_wreg_wb", WriteReg_WB, 7);

    // Load acknowledged three cycles after the request.
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 32'h100, 0, 0, 5'd3);
    stall_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (stall_MEM) stall_cycles++;
      if (c > 0) checkOutput("load_bubble_rw", RegWrite_WB, 0);
      step();
    end
    checkOutput("load_stall_cycles", stall_cycles, 3);
    checkOutput("load_rdata_wb", ReadData_WB, 32'hDEADBEEF);
    checkOutput("load_m2r_wb", MemToReg_WB, 1);
    checkOutput("load_rw_wb", RegWrite_WB, 1);
    dmem_ack = 1'b0;

    // Branch riding on a stalled load: redirect only at completion.
    applyStimulus(1, 0, 1, 1, 1, 0, 1, 32'h104, 0, 32'h40, 5'd4);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_1234;
      end
      @(negedge clk);
      checkOutput("brload_pcsrc", PCSrc_MEM, (c == 2) ? 1 : 0);
      step();
    end
    dmem_ack = 1'b0;

    // Zero-wait store, then a back-to-back zero-wait load.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h200, 32'h12345678, 0, 5'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    checkOutput("st_we", dmem_we, 1);
    checkOutput("st_wdata", dmem_wdata, 32'h12345678);
    checkOutput("st_req", dmem_req, 1);
    checkOutput("st_stall", stall_MEM, 0);
    step();
    checkOutput("st_rw_wb", RegWrite_WB, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 32'h204, 0, 0, 5'd9);
    dmem_rdata = 32'h0000_55AA;
    @(negedge clk);
    checkOutput("b2b_req", dmem_req, 1);
    checkOutput("b2b_stall", stall_MEM, 0);
    step();
    checkOutput("b2b_rdata_wb", ReadData_WB, 32'h55AA);
    checkOutput("b2b_rw_wb", RegWrite_WB, 1);
    dmem_ack = 1'b0;

    // Load that is never acknowledged: four stalls, then the abort cycle.
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 32'h300, 0, 0, 5'd5);
    stall_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stall_MEM) stall_cycles++;
      if (c == 4) begin
        checkOutput("to_abort_req", dmem_req, 0);
        checkOutput("to_abort_stall", stall_MEM, 0);
      end
      step();
    end
    checkOutput("to_stall_cycles", stall_cycles, 4);
    checkOutput("to_bus_err", bus_err, 1);
    checkOutput("to_rw_wb", RegWrite_WB, 0);
    checkOutput("to_rdata_wb", ReadData_WB, 0);

    // Misaligned load.
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 32'h102, 0, 0, 5'd6);
    @(negedge clk);
    checkOutput("mis_req", dmem_req, 0);
    checkOutput("mis_stall", stall_MEM, 0);
    step();
    checkOutput("mis_err", misalign_err, 1);
    checkOutput("mis_rw_wb", RegWrite_WB, 0);

    // Branch/jump redirection on non-memory instructions.
    for (int c = 0; c < 4; c++) begin
      logic [2:0] bjz;
      bjz = 3'(c + 4);
      if (c == 3) bjz = 3'b010;
      applyStimulus(0, 0, 0, 1, bjz[2], bjz[1], bjz[0], 32'h10, 0, 32'h40, 5'd2);
      @(negedge clk);
      checkOutput("br_pcsrc", PCSrc_MEM, (bjz[2] && bjz[0]) || bjz[1]);
      step();
    end

    // Reset two cycles into a pending load; a late ack is ignored.
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 32'h400, 0, 0, 5'd8);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("rw_req_drop", dmem_req, 0);
    checkOutput("rw_stall_drop", stall_MEM, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("rw_late_stall", stall_MEM, 0);
    checkOutput("rw_late_req", dmem_req, 0);
    step();
    checkOutput("rw_late_rdata_wb", ReadData_WB, 0);
    checkOutput("rw_late_rw_wb", RegWrite_WB, 0);
    checkOutput("rw_bus_err", bus_err, 0);
    checkOutput("rw_misalign_err", misalign_err, 0);
    dmem_ack = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a run that never reaches its end.
  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
